cluster_periph_demux: RTL and testbench

Parametrised request demultiplexer for the cluster peripheral interconnect. It routes one core-side data port (req/add/we/data/be with gnt/r_valid/r_data) to `NumSlv` address-windowed peripheral slaves. It adds two things the fixed mapping lacks: an outstanding-transaction counter that keeps responses in order across target switches, and a built-in error responder for unmapped windows. It sits between each master plug of the peripheral crossbar and the slave ports (EOC, timer, event unit, HWPE, DMA, HMR, ...).

---
 rtl/cluster_periph_demux_if.sv | 40 ++++
 rtl/cluster_periph_demux.sv | 131 +++++++++++++
 tb/tb_cluster_periph_demux.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_periph_demux_if.sv
// Core-side data port plus per-slave peripheral signals of the cluster peripheral demux.
// The slave modport is the demux view; the master modport is the surrounding core/peripheral view.
interface cluster_periph_demux_if #(
    parameter int unsigned NumSlv = 12
);
    logic                         mst_req_i;
    logic [31:0]                  mst_add_i;
    logic                         mst_we_i;
    logic [31:0]                  mst_wdata_i;
    logic [3:0]                   mst_be_i;
    logic                         mst_gnt_o;
    logic                         mst_r_valid_o;
    logic [31:0]                  mst_r_data_o;
    logic                         mst_r_err_o;
    logic [NumSlv-1:0]            slv_req_o;
    logic [31:0]                  slv_add_o;
    logic                         slv_we_o;
    logic [31:0]                  slv_wdata_o;
    logic [3:0]                   slv_be_o;
    logic [NumSlv-1:0]            slv_gnt_i;
    logic [NumSlv-1:0]            slv_r_valid_i;
    logic [NumSlv-1:0][31:0]      slv_r_data_i;
    logic                         spurious_rsp_o;

    modport slave (
        input  mst_req_i, mst_add_i, mst_we_i, mst_wdata_i, mst_be_i,
        output mst_gnt_o, mst_r_valid_o, mst_r_data_o, mst_r_err_o,
        output slv_req_o, slv_add_o, slv_we_o, slv_wdata_o, slv_be_o,
        input  slv_gnt_i, slv_r_valid_i, slv_r_data_i,
        output spurious_rsp_o
    );

    modport master (
        output mst_req_i, mst_add_i, mst_we_i, mst_wdata_i, mst_be_i,
        input  mst_gnt_o, mst_r_valid_o, mst_r_data_o, mst_r_err_o,
        input  slv_req_o, slv_add_o, slv_we_o, slv_wdata_o, slv_be_o,
        output slv_gnt_i, slv_r_valid_i, slv_r_data_i,
        input  spurious_rsp_o
    );
endinterface

// File: rtl/cluster_periph_demux.sv
// Address-windowed request demux with in-order outstanding tracking and an
// error responder for unmapped windows.
module cluster_periph_demux #(
    parameter int unsigned NumSlv         = 12,
    parameter int unsigned AddrWinLsb     = 10,
    parameter int unsigned SlvIdxWidth    = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [31:0] ErrData        = 32'hBADACCE5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cluster_periph_demux_if.slave  bus
);

    localparam int unsigned TgtW = $clog2(NumSlv + 1);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumSlv);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [SlvIdxWidth-1:0] idx;
    logic                   tgt_err;
    logic [TgtW-1:0]        tgt;
    logic [TgtW-1:0]        tgt_q;
    logic [CntW-1:0]        cnt_q;
    logic [CntW-1:0]        cnt_d;
    logic                   err_pend_q;
    logic                   allowed;
    logic                   sel_gnt;
    logic                   gnt;
    logic                   accept;
    logic [NumSlv-1:0]      slv_req;
    logic                   rsp_valid;
    logic [31:0]            rsp_data;
    logic                   rsp_err;
    logic                   spurious;

    assign idx     = bus.mst_add_i[AddrWinLsb +: SlvIdxWidth];
    assign tgt_err = 32'(idx) >= NumSlv;
    assign tgt     = tgt_err ? ErrTgt : TgtW'(idx);

    // Issue gating: a target switch waits until every earlier response has drained.
    always_comb begin
        slv_req = '0;
        gnt     = 1'b0;
        sel_gnt = 1'b0;
        allowed = (cnt_q < CntMax) && ((cnt_q == '0) || (tgt == tgt_q));
        for (int unsigned k = 0; k < NumSlv; k++) begin
            if (tgt == TgtW'(k)) begin
                sel_gnt = bus.slv_gnt_i[k];
            end
        end
        if (allowed && !rst_i) begin
            if (tgt_err) begin
                gnt = bus.mst_req_i;
            end else begin
                gnt = sel_gnt;
                for (int unsigned k = 0; k < NumSlv; k++) begin
                    slv_req[k] = bus.mst_req_i && (tgt == TgtW'(k));
                end
            end
        end
    end

    assign accept = bus.mst_req_i & gnt;

    // Response path: forward only the slave currently owning the outstanding stream.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        spurious  = 1'b0;
        if (tgt_q == ErrTgt) begin
            rsp_valid = err_pend_q;
            rsp_data  = ErrData;
            rsp_err   = 1'b1;
        end else if (cnt_q != '0) begin
            for (int unsigned k = 0; k < NumSlv; k++) begin
                if (tgt_q == TgtW'(k)) begin
                    rsp_valid = bus.slv_r_valid_i[k];
                    rsp_data  = bus.slv_r_data_i[k];
                end
            end
        end
        for (int unsigned k = 0; k < NumSlv; k++) begin
            if (bus.slv_r_valid_i[k] && ((cnt_q == '0) || (tgt_q != TgtW'(k)))) begin
                spurious = 1'b1;
            end
        end
        if (rst_i) begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
            rsp_err   = 1'b0;
            spurious  = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !rsp_valid && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!accept && rsp_valid && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            tgt_q      <= '0;
            err_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            err_pend_q <= accept && tgt_err;
            if (accept) begin
                tgt_q <= tgt;
            end
        end
    end

    assign bus.mst_gnt_o      = gnt;
    assign bus.mst_r_valid_o  = rsp_valid;
    assign bus.mst_r_data_o   = rsp_data;
    assign bus.mst_r_err_o    = rsp_err;
    assign bus.slv_req_o      = slv_req;
    assign bus.spurious_rsp_o = spurious;
    assign bus.slv_add_o      = bus.mst_add_i;
    assign bus.slv_we_o       = bus.mst_we_i;
    assign bus.slv_wdata_o    = bus.mst_wdata_i;
    assign bus.slv_be_o       = bus.mst_be_i;

endmodule

// File: tb/tb_cluster_periph_demux.sv
// Directed scenarios followed by randomized traffic against a queue-based model of
// in-order outstanding transactions.
module tb_cluster_periph_demux;

    localparam int          NS   = 12;
    localparam int          MAXO = 4;
    localparam logic [31:0] ERRD = 32'hBADACCE5;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cluster_periph_demux_if #(.NumSlv(NS)) bus ();

    cluster_periph_demux dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        bus.mst_req_i     = 1'b0;
        bus.slv_gnt_i     = '0;
        bus.slv_r_valid_i = '0;
    endtask

    // reference model state
    int          q[$];
    int          pend[NS];
    logic        err_due;
    logic        have_req;
    logic [31:0] cur_add;
    int          last_idx;

    initial begin
        int          tgt, n, front;
        logic        allowed, exp_gnt, exp_rv, exp_sp, g_sel, accept;
        logic [11:0] exp_req;
        logic [31:0] exp_data, wd;

        rst = 1'b1;
        idle();
        bus.mst_add_i    = '0;
        bus.mst_we_i     = 1'b0;
        bus.mst_wdata_i  = '0;
        bus.mst_be_i     = '0;
        bus.slv_r_data_i = '0;
        step();
        step();

        // outputs quiet during reset, payload still follows
        bus.mst_req_i     = 1'b1;
        bus.mst_add_i     = 32'h0000_0400;
        bus.mst_wdata_i   = 32'hCAFE_F00D;
        bus.mst_be_i      = 4'hA;
        bus.mst_we_i      = 1'b1;
        bus.slv_gnt_i     = '1;
        bus.slv_r_valid_i = '1;
        settle();
        chkb("rst_gnt", bus.mst_gnt_o, 1'b0);
        chkw("rst_slv_req", 32'(bus.slv_req_o), 32'h0);
        chkb("rst_rvalid", bus.mst_r_valid_o, 1'b0);
        chkw("rst_rdata", bus.mst_r_data_o, 32'h0);
        chkb("rst_rerr", bus.mst_r_err_o, 1'b0);
        chkb("rst_spur", bus.spurious_rsp_o, 1'b0);
        chkw("rst_add", bus.slv_add_o, 32'h0000_0400);
        chkw("rst_wdata", bus.slv_wdata_o, 32'hCAFE_F00D);
        chkw("rst_be", 32'(bus.slv_be_o), 32'hA);
        chkb("rst_we", bus.slv_we_o, 1'b1);
        step();
        rst = 1'b0;
        idle();
        bus.mst_we_i = 1'b0;
        step();

        // slave 1 read with next-cycle response
        bus.mst_req_i = 1'b1;
        bus.mst_add_i = 32'h0000_0400;
        bus.slv_gnt_i = 12'h002;
        settle();
        chkb("s1_gnt", bus.mst_gnt_o, 1'b1);
        chkw("s1_req", 32'(bus.slv_req_o), 32'h002);
        step();
        idle();
        bus.slv_r_valid_i   = 12'h002;
        bus.slv_r_data_i[1] = 32'h1234_5678;
        settle();
        chkb("s1_rvalid", bus.mst_r_valid_o, 1'b1);
        chkw("s1_rdata", bus.mst_r_data_o, 32'h1234_5678);
        chkb("s1_rerr", bus.mst_r_err_o, 1'b0);
        chkb("s1_spur", bus.spurious_rsp_o, 1'b0);
        step();
        idle();
        bus.mst_req_i = 1'b1;
        bus.mst_add_i = 32'h0000_1800;
        bus.slv_gnt_i = 12'h040;
        settle();
        chkb("s1_drained_gnt6", bus.mst_gnt_o, 1'b1);
        step();
        idle();
        bus.slv_r_valid_i = 12'h040;
        step();
        idle();

        // unmapped window answered by the error responder
        bus.mst_req_i = 1'b1;
        bus.mst_add_i = 32'h0000_3C00;
        settle();
        chkb("err_gnt", bus.mst_gnt_o, 1'b1);
        chkw("err_slv_req", 32'(bus.slv_req_o), 32'h0);
        step();
        idle();
        settle();
        chkb("err_rvalid", bus.mst_r_valid_o, 1'b1);
        chkw("err_rdata", bus.mst_r_data_o, ERRD);
        chkb("err_rerr", bus.mst_r_err_o, 1'b1);
        step();
        settle();
        chkb("err_once", bus.mst_r_valid_o, 1'b0);
        step();

        // fill to the outstanding limit on slave 4
        bus.mst_req_i = 1'b1;
        bus.mst_add_i = 32'h0000_1000;
        bus.slv_gnt_i = 12'h010;
        for (int i = 0; i < MAXO; i++) begin
            settle();
            chkb("full_fill_gnt", bus.mst_gnt_o, 1'b1);
            step();
        end
        settle();
        chkb("full_stall_gnt", bus.mst_gnt_o, 1'b0);
        chkw("full_stall_req", 32'(bus.slv_req_o), 32'h0);
        step();
        bus.slv_r_valid_i = 12'h010;
        settle();
        chkb("full_retire_rv", bus.mst_r_valid_o, 1'b1);
        chkb("full_retire_gnt", bus.mst_gnt_o, 1'b0);
        step();
        bus.slv_r_valid_i = '0;
        settle();
        chkb("full_release_gnt", bus.mst_gnt_o, 1'b1);
        chkw("full_release_req", 32'(bus.slv_req_o), 32'h010);
        step();
        bus.mst_req_i     = 1'b0;
        bus.slv_r_valid_i = 12'h010;
        for (int i = 0; i < MAXO; i++) begin
            settle();
            chkb("full_drain_rv", bus.mst_r_valid_o, 1'b1);
            step();
        end
        settle();
        chkb("full_extra_rv", bus.mst_r_valid_o, 1'b0);
        chkb("full_extra_spur", bus.spurious_rsp_o, 1'b1);
        step();
        idle();
        step();

        // target switch blocked until slave 1 responds
        bus.mst_req_i = 1'b1;
        bus.mst_add_i = 32'h0000_0400;
        bus.slv_gnt_i = 12'h002;
        settle();
        chkb("sw_gnt1", bus.mst_gnt_o, 1'b1);
        step();
        bus.mst_add_i = 32'h0000_1800;
        bus.slv_gnt_i = 12'h040;
        settle();
        chkb("sw_block_gnt", bus.mst_gnt_o, 1'b0);
        chkw("sw_block_req", 32'(bus.slv_req_o), 32'h0);
        step();
        bus.slv_r_valid_i   = 12'h002;
        bus.slv_r_data_i[1] = 32'h1111_0001;
        settle();
        chkb("sw_rsp1_rv", bus.mst_r_valid_o, 1'b1);
        chkw("sw_rsp1_data", bus.mst_r_data_o, 32'h1111_0001);
        chkb("sw_retire_gnt", bus.mst_gnt_o, 1'b0);
        step();
        bus.slv_r_valid_i = '0;
        settle();
        chkb("sw_gnt6", bus.mst_gnt_o, 1'b1);
        chkw("sw_req6", 32'(bus.slv_req_o), 32'h040);
        step();
        bus.mst_req_i       = 1'b0;
        bus.slv_r_valid_i   = 12'h040;
        bus.slv_r_data_i[6] = 32'h6666_0006;
        settle();
        chkb("sw_rsp6_rv", bus.mst_r_valid_o, 1'b1);
        chkw("sw_rsp6_data", bus.mst_r_data_o, 32'h6666_0006);
        step();
        idle();
        step();

        // reset with two outstanding; late response is spurious
        bus.mst_req_i = 1'b1;
        bus.mst_add_i = 32'h0000_0400;
        bus.slv_gnt_i = 12'h002;
        step();
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.slv_r_valid_i = 12'h002;
        settle();
        chkb("rstmid_rv", bus.mst_r_valid_o, 1'b0);
        chkb("rstmid_spur", bus.spurious_rsp_o, 1'b1);
        step();
        idle();
        settle();
        chkb("rstmid_spur_clr", bus.spurious_rsp_o, 1'b0);
        step();

        // error access then slave access back to back
        bus.mst_req_i = 1'b1;
        bus.mst_add_i = 32'h0000_3C00;
        settle();
        chkb("eb_err_gnt", bus.mst_gnt_o, 1'b1);
        step();
        bus.mst_add_i = 32'h0000_0400;
        bus.slv_gnt_i = 12'h002;
        settle();
        chkb("eb_wait_gnt", bus.mst_gnt_o, 1'b0);
        chkw("eb_wait_req", 32'(bus.slv_req_o), 32'h0);
        chkb("eb_err_rv", bus.mst_r_valid_o, 1'b1);
        chkb("eb_err_flag", bus.mst_r_err_o, 1'b1);
        step();
        settle();
        chkb("eb_slv_gnt", bus.mst_gnt_o, 1'b1);
        chkw("eb_slv_req", 32'(bus.slv_req_o), 32'h002);
        step();
        bus.mst_req_i       = 1'b0;
        bus.slv_r_valid_i   = 12'h002;
        bus.slv_r_data_i[1] = 32'hA5A5_0001;
        settle();
        chkb("eb_slv_rv", bus.mst_r_valid_o, 1'b1);
        chkb("eb_slv_err", bus.mst_r_err_o, 1'b0);
        chkw("eb_slv_data", bus.mst_r_data_o, 32'hA5A5_0001);
        step();
        idle();

        // randomized traffic against the in-order queue model
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        for (int k = 0; k < NS; k++) pend[k] = 0;
        err_due  = 1'b0;
        have_req = 1'b0;
        cur_add  = '0;
        last_idx = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!have_req && $urandom_range(0, 3) != 0) begin
                have_req = 1'b1;
                if ($urandom_range(0, 1) == 0) last_idx = int'($urandom_range(0, 15));
                cur_add        = $urandom;
                cur_add[13:10] = 4'(last_idx);
            end
            wd                = $urandom;
            bus.mst_req_i     = have_req;
            bus.mst_add_i     = cur_add;
            bus.mst_we_i      = 1'($urandom_range(0, 1));
            bus.mst_wdata_i   = wd;
            bus.mst_be_i      = 4'($urandom);
            bus.slv_gnt_i     = 12'($urandom);
            for (int k = 0; k < NS; k++) begin
                if (pend[k] > 0) bus.slv_r_valid_i[k] = ($urandom_range(0, 2) != 0);
                else             bus.slv_r_valid_i[k] = ($urandom_range(0, 19) == 0);
                bus.slv_r_data_i[k] = $urandom;
            end
            settle();

            tgt     = (int'(cur_add[13:10]) < NS) ? int'(cur_add[13:10]) : NS;
            n       = q.size();
            front   = (n > 0) ? q[0] : -1;
            allowed = (n < MAXO) && (n == 0 || front == tgt);
            g_sel   = (tgt < NS) ? bus.slv_gnt_i[tgt] : have_req;
            exp_gnt = allowed && g_sel;
            exp_req = (allowed && tgt < NS && have_req) ? (12'(1) << tgt) : 12'h0;
            exp_rv  = (n > 0) && ((front == NS) ? err_due : bus.slv_r_valid_i[front]);
            exp_sp  = 1'b0;
            for (int k = 0; k < NS; k++) begin
                if (bus.slv_r_valid_i[k] && (n == 0 || front != k)) exp_sp = 1'b1;
            end

            chkb("rnd_gnt", bus.mst_gnt_o, exp_gnt);
            chkw("rnd_req", 32'(bus.slv_req_o), 32'(exp_req));
            chkb("rnd_rvalid", bus.mst_r_valid_o, exp_rv);
            chkb("rnd_spur", bus.spurious_rsp_o, exp_sp);
            chkw("rnd_add", bus.slv_add_o, cur_add);
            chkw("rnd_wdata", bus.slv_wdata_o, wd);
            if (exp_rv) begin
                exp_data = (front == NS) ? ERRD : bus.slv_r_data_i[front];
                chkw("rnd_rdata", bus.mst_r_data_o, exp_data);
                chkb("rnd_rerr", bus.mst_r_err_o, front == NS);
            end

            if (exp_rv) begin
                if (front != NS) pend[front]--;
                void'(q.pop_front());
            end
            accept  = have_req && exp_gnt;
            err_due = 1'b0;
            if (accept) begin
                q.push_back(tgt);
                if (tgt == NS) err_due = 1'b1;
                else           pend[tgt]++;
                have_req = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
